// File: rtl/slink_axi_pkg.sv
// slink_axi_pkg: AXI channel field offsets and response encodings shared by slink AXI blocks
package slink_axi_pkg;
  localparam int ID_LSB = 0;
  localparam int LEN_LSB = 8;
  localparam int AX_FIELDS_W = 38;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;
endpackage

// File: rtl/slink_axi_len_fifo.sv
// slink_axi_len_fifo: first-word-fall-through queue of AW burst lengths
module slink_axi_len_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push_ok, pop_ok;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop_ok) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end
endmodule

// File: rtl/slink_axi_tgt_flow_ctrl.sv
// slink_axi_tgt_flow_ctrl: limits outstanding AXI bursts, regenerates WLAST from AW length,
// and flags WLAST mismatches and unmatched responses.
module slink_axi_tgt_flow_ctrl
  import slink_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MAX_WR_OUT = 4,
  parameter int MAX_RD_OUT = 4
) (
  input  logic                                  axi_clk,
  input  logic                                  axi_reset,
  input  logic                                  enable,
  input  logic                                  err_clear,
  input  logic [AXI_ADDR_WIDTH+AX_FIELDS_W-1:0] up_aw_info,
  input  logic                                  up_awvalid,
  output logic                                  up_awready,
  output logic [AXI_ADDR_WIDTH+AX_FIELDS_W-1:0] dn_aw_info,
  output logic                                  dn_awvalid,
  input  logic                                  dn_awready,
  input  logic [AXI_ADDR_WIDTH+AX_FIELDS_W-1:0] up_ar_info,
  input  logic                                  up_arvalid,
  output logic                                  up_arready,
  output logic [AXI_ADDR_WIDTH+AX_FIELDS_W-1:0] dn_ar_info,
  output logic                                  dn_arvalid,
  input  logic                                  dn_arready,
  input  logic [7:0]                            up_wid,
  input  logic [AXI_DATA_WIDTH-1:0]             up_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]           up_wstrb,
  input  logic                                  up_wlast,
  input  logic                                  up_wvalid,
  output logic                                  up_wready,
  output logic [7:0]                            dn_wid,
  output logic [AXI_DATA_WIDTH-1:0]             dn_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]           dn_wstrb,
  output logic                                  dn_wlast,
  output logic                                  dn_wvalid,
  input  logic                                  dn_wready,
  input  logic [7:0]                            dn_bid,
  input  logic [1:0]                            dn_bresp,
  input  logic                                  dn_bvalid,
  output logic                                  dn_bready,
  output logic [7:0]                            up_bid,
  output logic [1:0]                            up_bresp,
  output logic                                  up_bvalid,
  input  logic                                  up_bready,
  input  logic [7:0]                            dn_rid,
  input  logic [AXI_DATA_WIDTH-1:0]             dn_rdata,
  input  logic [1:0]                            dn_rresp,
  input  logic                                  dn_rlast,
  input  logic                                  dn_rvalid,
  output logic                                  dn_rready,
  output logic [7:0]                            up_rid,
  output logic [AXI_DATA_WIDTH-1:0]             up_rdata,
  output logic [1:0]                            up_rresp,
  output logic                                  up_rlast,
  output logic                                  up_rvalid,
  input  logic                                  up_rready,
  output logic [3:0]                            wr_out_cnt,
  output logic [3:0]                            rd_out_cnt,
  output logic                                  wlast_err,
  output logic                                  resp_err
);
  logic aw_allow, ar_allow, aw_hs, ar_hs, w_hs, b_hs, rl_hs, wr_under, rd_under;
  logic lenq_full, lenq_empty;
  logic [7:0] lenq_head, beat;
  assign aw_allow = axi_reset & enable & (wr_out_cnt < 4'(MAX_WR_OUT)) & ~lenq_full;
  assign ar_allow = axi_reset & enable & (rd_out_cnt < 4'(MAX_RD_OUT));
  assign dn_aw_info = up_aw_info;
  assign dn_awvalid = up_awvalid & aw_allow;
  assign up_awready = dn_awready & aw_allow;
  assign dn_ar_info = up_ar_info;
  assign dn_arvalid = up_arvalid & ar_allow;
  assign up_arready = dn_arready & ar_allow;
  assign dn_wid = up_wid;
  assign dn_wdata = up_wdata;
  assign dn_wstrb = up_wstrb;
  assign dn_wlast = beat == lenq_head;
  assign dn_wvalid = up_wvalid & ~lenq_empty;
  assign up_wready = dn_wready & ~lenq_empty;
  assign up_bid = dn_bid;
  assign up_bresp = dn_bresp;
  assign up_bvalid = dn_bvalid;
  assign dn_bready = up_bready;
  assign up_rid = dn_rid;
  assign up_rdata = dn_rdata;
  assign up_rresp = dn_rresp;
  assign up_rlast = dn_rlast;
  assign up_rvalid = dn_rvalid;
  assign dn_rready = up_rready;
  assign aw_hs = up_awvalid & up_awready;
  assign ar_hs = up_arvalid & up_arready;
  assign w_hs = up_wvalid & up_wready;
  assign b_hs = dn_bvalid & up_bready;
  assign rl_hs = dn_rvalid & up_rready & dn_rlast;
  assign wr_under = b_hs & (wr_out_cnt == '0);
  assign rd_under = rl_hs & (rd_out_cnt == '0);
  slink_axi_len_fifo #(.DEPTH(MAX_WR_OUT)) u_lenq (
    .clk(axi_clk),
    .rst_n(axi_reset),
    .push(aw_hs),
    .din(up_aw_info[LEN_LSB +: 8]),
    .pop(w_hs & dn_wlast),
    .dout(lenq_head),
    .full(lenq_full),
    .empty(lenq_empty)
  );
  // a response with nothing outstanding is flagged rather than wrapping the count
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      wr_out_cnt <= '0;
      rd_out_cnt <= '0;
      beat <= '0;
      wlast_err <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      wr_out_cnt <= wr_out_cnt + 4'(aw_hs) - 4'(b_hs & ~wr_under);
      rd_out_cnt <= rd_out_cnt + 4'(ar_hs) - 4'(rl_hs & ~rd_under);
      beat <= w_hs ? (dn_wlast ? '0 : beat + 8'd1) : beat;
      wlast_err <= (w_hs & (up_wlast != dn_wlast)) | (wlast_err & ~err_clear);
      resp_err <= wr_under | rd_under | (resp_err & ~err_clear);
    end
  end
endmodule

// File: tb/tb_slink_axi_tgt_flow_ctrl.sv
// tb_slink_axi_tgt_flow_ctrl: directed scenario tests with hand-computed expectations
module tb_slink_axi_tgt_flow_ctrl;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = AW + 38;
  logic axi_clk = 0, axi_reset = 0, enable = 0, err_clear = 0;
  logic [IW-1:0] up_aw_info = '0, dn_aw_info, up_ar_info = '0, dn_ar_info;
  logic up_awvalid = 0, up_awready, dn_awvalid, dn_awready = 0;
  logic up_arvalid = 0, up_arready, dn_arvalid, dn_arready = 0;
  logic [7:0] up_wid = '0, dn_wid;
  logic [DW-1:0] up_wdata = '0, dn_wdata;
  logic [DW/8-1:0] up_wstrb = '0, dn_wstrb;
  logic up_wlast = 0, dn_wlast, up_wvalid = 0, up_wready, dn_wvalid, dn_wready = 0;
  logic [7:0] dn_bid = '0, up_bid;
  logic [1:0] dn_bresp = '0, up_bresp;
  logic dn_bvalid = 0, dn_bready, up_bvalid, up_bready = 0;
  logic [7:0] dn_rid = '0, up_rid;
  logic [DW-1:0] dn_rdata = '0, up_rdata;
  logic [1:0] dn_rresp = '0, up_rresp;
  logic dn_rlast = 0, dn_rvalid = 0, dn_rready, up_rlast, up_rvalid, up_rready = 0;
  logic [3:0] wr_out_cnt, rd_out_cnt;
  logic wlast_err, resp_err;
  int checks = 0, errors = 0;

  always #5 axi_clk = ~axi_clk;

  slink_axi_tgt_flow_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_WR_OUT(4), .MAX_RD_OUT(1)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .enable(enable), .err_clear(err_clear),
    .up_aw_info(up_aw_info), .up_awvalid(up_awvalid), .up_awready(up_awready),
    .dn_aw_info(dn_aw_info), .dn_awvalid(dn_awvalid), .dn_awready(dn_awready),
    .up_ar_info(up_ar_info), .up_arvalid(up_arvalid), .up_arready(up_arready),
    .dn_ar_info(dn_ar_info), .dn_arvalid(dn_arvalid), .dn_arready(dn_arready),
    .up_wid(up_wid), .up_wdata(up_wdata), .up_wstrb(up_wstrb), .up_wlast(up_wlast),
    .up_wvalid(up_wvalid), .up_wready(up_wready),
    .dn_wid(dn_wid), .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb), .dn_wlast(dn_wlast),
    .dn_wvalid(dn_wvalid), .dn_wready(dn_wready),
    .dn_bid(dn_bid), .dn_bresp(dn_bresp), .dn_bvalid(dn_bvalid), .dn_bready(dn_bready),
    .up_bid(up_bid), .up_bresp(up_bresp), .up_bvalid(up_bvalid), .up_bready(up_bready),
    .dn_rid(dn_rid), .dn_rdata(dn_rdata), .dn_rresp(dn_rresp), .dn_rlast(dn_rlast),
    .dn_rvalid(dn_rvalid), .dn_rready(dn_rready),
    .up_rid(up_rid), .up_rdata(up_rdata), .up_rresp(up_rresp), .up_rlast(up_rlast),
    .up_rvalid(up_rvalid), .up_rready(up_rready),
    .wr_out_cnt(wr_out_cnt), .rd_out_cnt(rd_out_cnt), .wlast_err(wlast_err), .resp_err(resp_err)
  );

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic logic [IW-1:0] ax(input logic [7:0] len, input logic [7:0] id);
    return {32'h0000_1000, 22'h0, len, id};
  endfunction

  task automatic idle();
    up_awvalid = 0; up_arvalid = 0; up_wvalid = 0; up_wlast = 0;
    dn_bvalid = 0; dn_rvalid = 0; dn_rlast = 0; err_clear = 0;
  endtask

  task automatic test_reset();
    enable = 1; dn_awready = 1; dn_arready = 1; dn_wready = 1; up_bready = 1; up_rready = 1;
    up_awvalid = 1; up_arvalid = 1; up_wvalid = 1; up_aw_info = ax(8'd0, 8'h11);
    #1;
    checks++;
    if ({dn_awvalid, up_awready, dn_arvalid, up_arready, dn_wvalid, up_wready} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes: got %b exp 000000", {dn_awvalid, up_awready, dn_arvalid, up_arready, dn_wvalid, up_wready});
    end
    tick();
    checks++;
    if ({wr_out_cnt, rd_out_cnt, wlast_err, resp_err} !== 10'b0) begin
      errors++; $display("FAIL reset_state: got %h exp 0", {wr_out_cnt, rd_out_cnt, wlast_err, resp_err});
    end
    up_arvalid = 0; up_wvalid = 0;
    axi_reset = 1;
    #1;
    checks++;
    if (up_awready !== 1'b1 || dn_aw_info !== ax(8'd0, 8'h11)) begin
      errors++; $display("FAIL reset_release_aw: got rdy %b info %h exp 1 %h", up_awready, dn_aw_info, ax(8'd0, 8'h11));
    end
    tick();
    checks++;
    if (wr_out_cnt !== 4'd1) begin errors++; $display("FAIL reset_first_aw_cnt: got %0d exp 1", wr_out_cnt); end
    idle();
    up_wvalid = 1; up_wlast = 1; dn_bvalid = 1;
    tick();
    idle();
  endtask

  task automatic test_aw_limit();
    for (int i = 0; i < 5; i++) begin
      up_awvalid = 1; up_aw_info = ax(8'd0, 8'(i));
      #1;
      checks++;
      if (up_awready !== (i < 4)) begin errors++; $display("FAIL aw_limit_ready%0d: got %b exp %b", i, up_awready, i < 4); end
      if (i < 4) tick();
    end
    checks++;
    if (wr_out_cnt !== 4'd4) begin errors++; $display("FAIL aw_limit_cnt: got %0d exp 4", wr_out_cnt); end
    up_wvalid = 1; up_wlast = 1;
    #1;
    checks++;
    if (dn_wlast !== 1'b1) begin errors++; $display("FAIL aw_limit_wlast: got %b exp 1", dn_wlast); end
    tick();
    up_wvalid = 0;
    #1;
    checks++;
    if (up_awready !== 1'b0) begin errors++; $display("FAIL aw_limit_still_blocked: got %b exp 0", up_awready); end
    dn_bvalid = 1;
    tick();
    dn_bvalid = 0;
    #1;
    checks++;
    if (up_awready !== 1'b1 || wr_out_cnt !== 4'd3) begin
      errors++; $display("FAIL aw_limit_after_b: got rdy %b cnt %0d exp 1 3", up_awready, wr_out_cnt);
    end
    tick();
    up_awvalid = 0;
    checks++;
    if (wr_out_cnt !== 4'd4) begin errors++; $display("FAIL aw_limit_fifth: got %0d exp 4", wr_out_cnt); end
    up_wvalid = 1; up_wlast = 1; dn_bvalid = 1;
    repeat (4) tick();
    idle();
    checks++;
    if (wr_out_cnt !== 4'd0 || wlast_err !== 1'b0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL aw_limit_drain: got cnt %0d we %b re %b exp 0 0 0", wr_out_cnt, wlast_err, resp_err);
    end
  endtask

  task automatic test_w_gating();
    up_wvalid = 1; up_wlast = 0; up_wdata = 64'hAAAA;
    #1;
    checks++;
    if (up_wready !== 1'b0 || dn_wvalid !== 1'b0) begin
      errors++; $display("FAIL w_no_aw: got rdy %b vld %b exp 0 0", up_wready, dn_wvalid);
    end
    tick();
    up_awvalid = 1; up_aw_info = ax(8'd3, 8'h22);
    #1;
    checks++;
    if (up_wready !== 1'b0) begin errors++; $display("FAIL w_no_bypass: got %b exp 0", up_wready); end
    tick();
    up_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      up_wlast = (i == 3); up_wdata = 64'(i + 'h50);
      #1;
      checks++;
      if (up_wready !== 1'b1 || dn_wlast !== (i == 3) || dn_wdata !== 64'(i + 'h50)) begin
        errors++; $display("FAIL w_beat%0d: got rdy %b last %b data %h exp 1 %b %h", i, up_wready, dn_wlast, dn_wdata, i == 3, 64'(i + 'h50));
      end
      tick();
    end
    checks++;
    if (up_wready !== 1'b0 || wlast_err !== 1'b0) begin
      errors++; $display("FAIL w_queue_empty: got rdy %b err %b exp 0 0", up_wready, wlast_err);
    end
    idle();
    dn_bvalid = 1;
    tick();
    idle();
  endtask

  task automatic test_wlast_err();
    up_awvalid = 1; up_aw_info = ax(8'd1, 8'h33);
    tick();
    idle();
    up_wvalid = 1; up_wlast = 1;
    #1;
    checks++;
    if (dn_wlast !== 1'b0) begin errors++; $display("FAIL wlast_regen: got %b exp 0", dn_wlast); end
    tick();
    checks++;
    if (wlast_err !== 1'b1) begin errors++; $display("FAIL wlast_err_set: got %b exp 1", wlast_err); end
    tick();
    up_wvalid = 0;
    checks++;
    if (wlast_err !== 1'b1) begin errors++; $display("FAIL wlast_err_sticky: got %b exp 1", wlast_err); end
    err_clear = 1; dn_bvalid = 1;
    tick();
    idle();
    checks++;
    if (wlast_err !== 1'b0 || wr_out_cnt !== 4'd0) begin
      errors++; $display("FAIL wlast_err_clear: got err %b cnt %0d exp 0 0", wlast_err, wr_out_cnt);
    end
  endtask

  task automatic test_same_cycle();
    up_awvalid = 1; up_aw_info = ax(8'd0, 8'h44);
    repeat (2) tick();
    dn_bvalid = 1;
    tick();
    idle();
    checks++;
    if (wr_out_cnt !== 4'd2) begin errors++; $display("FAIL aw_b_same_cycle: got %0d exp 2", wr_out_cnt); end
    for (int i = 0; i < 3; i++) begin
      up_wvalid = 1; up_wlast = 1; dn_bvalid = (i < 2);
      tick();
    end
    idle();
    dn_bvalid = 1;
    tick();
    checks++;
    if (wr_out_cnt !== 4'd0 || resp_err !== 1'b1) begin
      errors++; $display("FAIL b_underflow: got cnt %0d err %b exp 0 1", wr_out_cnt, resp_err);
    end
    err_clear = 1;
    tick();
    checks++;
    if (resp_err !== 1'b1) begin errors++; $display("FAIL resp_err_new_wins: got %b exp 1", resp_err); end
    dn_bvalid = 0;
    tick();
    idle();
    checks++;
    if (resp_err !== 1'b0) begin errors++; $display("FAIL resp_err_clear: got %b exp 0", resp_err); end
  endtask

  task automatic test_rd_limit();
    up_arvalid = 1; up_ar_info = ax(8'd7, 8'h55);
    #1;
    checks++;
    if (up_arready !== 1'b1 || dn_arvalid !== 1'b1) begin
      errors++; $display("FAIL ar_first: got rdy %b vld %b exp 1 1", up_arready, dn_arvalid);
    end
    tick();
    checks++;
    if (rd_out_cnt !== 4'd1 || up_arready !== 1'b0) begin
      errors++; $display("FAIL ar_blocked: got cnt %0d rdy %b exp 1 0", rd_out_cnt, up_arready);
    end
    for (int i = 0; i < 8; i++) begin
      dn_rvalid = 1; dn_rlast = (i == 7); dn_rdata = 64'(i);
      #1;
      checks++;
      if (up_arready !== 1'b0 || up_rvalid !== 1'b1 || dn_rready !== 1'b1 || up_rdata !== 64'(i)) begin
        errors++; $display("FAIL r_beat%0d: got ar %b rv %b rr %b d %h exp 0 1 1 %h", i, up_arready, up_rvalid, dn_rready, up_rdata, 64'(i));
      end
      tick();
    end
    dn_rvalid = 0; dn_rlast = 0;
    #1;
    checks++;
    if (rd_out_cnt !== 4'd0 || up_arready !== 1'b1) begin
      errors++; $display("FAIL r_last_release: got cnt %0d rdy %b exp 0 1", rd_out_cnt, up_arready);
    end
    tick();
    up_arvalid = 0;
    dn_rvalid = 1; dn_rlast = 1;
    tick();
    idle();
    checks++;
    if (rd_out_cnt !== 4'd0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL r_second_done: got cnt %0d err %b exp 0 0", rd_out_cnt, resp_err);
    end
  endtask

  task automatic test_enable_drop();
    up_awvalid = 1; up_aw_info = ax(8'd0, 8'h66);
    tick();
    enable = 0; up_wvalid = 1; up_wlast = 1; dn_bvalid = 1;
    #1;
    checks++;
    if (up_awready !== 1'b0 || dn_awvalid !== 1'b0 || up_wready !== 1'b1) begin
      errors++; $display("FAIL enable_drop: got awr %b awv %b wr %b exp 0 0 1", up_awready, dn_awvalid, up_wready);
    end
    tick();
    up_wvalid = 0; dn_bvalid = 0;
    #1;
    checks++;
    if (wr_out_cnt !== 4'd0 || up_awready !== 1'b0) begin
      errors++; $display("FAIL enable_drop_drain: got cnt %0d awr %b exp 0 0", wr_out_cnt, up_awready);
    end
    idle();
    enable = 1;
  endtask

  task automatic test_reset_mid_burst();
    up_awvalid = 1; up_aw_info = ax(8'd3, 8'h77);
    tick();
    up_awvalid = 0; up_wvalid = 1; up_wlast = 1;
    tick();
    up_wlast = 0;
    tick();
    up_awvalid = 1; up_aw_info = ax(8'd0, 8'h78);
    axi_reset = 0;
    #1;
    checks++;
    if ({wr_out_cnt, rd_out_cnt, wlast_err, resp_err} !== 10'b0 || {dn_awvalid, dn_wvalid, dn_arvalid, up_wready} !== 4'b0) begin
      errors++; $display("FAIL reset_mid_burst: got st %h vld %b exp 0 0000", {wr_out_cnt, rd_out_cnt, wlast_err, resp_err}, {dn_awvalid, dn_wvalid, dn_arvalid, up_wready});
    end
    tick();
    up_awvalid = 0;
    axi_reset = 1;
    #1;
    checks++;
    if (up_wready !== 1'b0 || dn_wvalid !== 1'b0 || wr_out_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_queue_empty: got rdy %b vld %b cnt %0d exp 0 0 0", up_wready, dn_wvalid, wr_out_cnt);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_aw_limit();
    test_w_gating();
    test_wlast_err();
    test_same_cycle();
    test_rd_limit();
    test_enable_drop();
    test_reset_mid_burst();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
